// File: rtl/fifo36_to_fifo19_pkg.sv
// Shared definitions for the 36-to-19 bit fifo width converter.
// Field offsets of both stream formats and the core FSM encoding.
package fifo36_to_fifo19_pkg;

  localparam int F36_W      = 36;
  localparam int F19_W      = 19;

  localparam int F36_OCC_HI = 35;
  localparam int F36_OCC_LO = 34;
  localparam int F36_EOF    = 33;
  localparam int F36_SOF    = 32;

  localparam int F19_OCC    = 18;
  localparam int F19_EOF    = 17;
  localparam int F19_SOF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HALF0 = 2'd1,
    ST_HALF1 = 2'd2
  } state_e;

  function automatic logic [F19_W-1:0] pack19(
    input logic        occ,
    input logic        eof,
    input logic        sof,
    input logic [15:0] data
  );
    return {occ, eof, sof, data};
  endfunction

endpackage

// File: rtl/fifo36_to_fifo19_fifo_short.sv
// Sixteen-entry register fifo used as the output tail buffer.
// Both handshakes depend only on the registered fill count.
module fifo_short #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] datain_i,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH-1:0] dataout_o,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i
);

  localparam int DEPTH = 16;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [3:0]       wr_q, wr_d;
  logic [3:0]       rd_q, rd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             wr_en;
  logic             rd_en;

  assign dst_rdy_o = (cnt_q != 5'd16);
  assign src_rdy_o = (cnt_q != 5'd0);
  assign dataout_o = mem_q[rd_q];

  assign wr_en = src_rdy_i & dst_rdy_o;
  assign rd_en = src_rdy_o & dst_rdy_i;

  always_comb begin
    wr_d  = wr_q + 4'(wr_en);
    rd_d  = rd_q + 4'(rd_en);
    cnt_d = cnt_q + 5'(wr_en) - 5'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= datain_i;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo36_to_fifo19.sv
// Splits 36-bit stream words into 19-bit half-word stream beats,
// with framing checks, packet counting and a registered tail fifo.
module fifo36_to_fifo19 #(
  parameter int LE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [35:0] f36_datain,
  input  logic        f36_src_rdy_i,
  output logic        f36_dst_rdy_o,
  output logic [18:0] f19_dataout,
  output logic        f19_src_rdy_o,
  input  logic        f19_dst_rdy_i,
  output logic [15:0] pkt_count,
  output logic        framing_err,
  output logic [31:0] debug
);

  import fifo36_to_fifo19_pkg::*;

  state_e            state_q, state_d;
  logic [F36_W-1:0]  word_q, word_d;
  logic              in_pkt_q, in_pkt_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              rdy36;
  logic              f36_xfer;
  logic              f19_xfer;
  logic              core_vld;
  logic              core_rdy;
  logic              last_half;
  logic [F19_W-1:0]  core_data;
  logic              fifo_rst;

  logic [1:0]        w_occ;
  logic              w_eof;
  logic              w_sof;
  logic              w_short;
  logic [15:0]       hw_first;
  logic [15:0]       hw_second;

  assign w_occ   = word_q[F36_OCC_HI:F36_OCC_LO];
  assign w_eof   = word_q[F36_EOF];
  assign w_sof   = word_q[F36_SOF];
  assign w_short = w_eof & ((w_occ == 2'd1) | (w_occ == 2'd2));

  assign hw_first  = (LE != 0) ? word_q[15:0]  : word_q[31:16];
  assign hw_second = (LE != 0) ? word_q[31:16] : word_q[15:0];

  assign f36_dst_rdy_o = rdy36 & reset_n;
  assign f36_xfer      = f36_src_rdy_i & f36_dst_rdy_o;
  assign f19_xfer      = f19_src_rdy_o & f19_dst_rdy_i;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    core_vld  = 1'b0;
    core_data = '0;
    last_half = 1'b0;
    rdy36     = 1'b0;
    unique case (state_q)
      ST_IDLE: rdy36 = 1'b1;
      ST_HALF0: begin
        core_vld  = 1'b1;
        last_half = w_short;
        core_data = pack19(w_eof & (w_occ == 2'd1),
                           w_short, w_sof, hw_first);
      end
      ST_HALF1: begin
        core_vld  = 1'b1;
        last_half = 1'b1;
        core_data = pack19(w_eof & (w_occ == 2'd3),
                           w_eof, 1'b0, hw_second);
      end
      default: ;
    endcase
    if (core_vld && core_rdy) begin
      if (last_half) rdy36 = 1'b1;
      else           state_d = ST_HALF1;
    end
    // refill straight into HALF0 so the output never bubbles
    if (rdy36) begin
      state_d = f36_src_rdy_i ? ST_HALF0 : ST_IDLE;
      if (f36_src_rdy_i) word_d = f36_datain;
    end
    if (clear) state_d = ST_IDLE;
  end

  always_comb begin
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    if (f36_xfer) begin
      if (f36_datain[F36_SOF] == in_pkt_q) err_d = 1'b1;
      in_pkt_d = ~f36_datain[F36_EOF];
    end
    if (clear) begin
      in_pkt_d = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign cnt_d = cnt_q + 16'(f19_xfer & f19_dataout[F19_EOF]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fifo_rst = ~reset_n;

  fifo_short #(
    .WIDTH(F19_W)
  ) u_tail (
    .clk      (clk),
    .reset    (fifo_rst),
    .clear    (clear),
    .datain_i (core_data),
    .src_rdy_i(core_vld),
    .dst_rdy_o(core_rdy),
    .dataout_o(f19_dataout),
    .src_rdy_o(f19_src_rdy_o),
    .dst_rdy_i(f19_dst_rdy_i)
  );

  assign pkt_count   = cnt_q;
  assign framing_err = err_q;
  assign debug       = {29'b0, err_q, state_q};

endmodule

// File: tb/tb_fifo36_to_fifo19.sv
// Directed bench for fifo36_to_fifo19: big- and little-endian
// instances share one stimulus stream and are checked side by side.
module tb_fifo36_to_fifo19;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [35:0] din = '0;
  logic        src = 1'b0;
  logic        dst19 = 1'b1;

  logic        dst0, dst1, s19_0, s19_1, fe0, fe1;
  logic [18:0] d0, d1;
  logic [15:0] pc0, pc1;
  logic [31:0] dbg0, dbg1;

  int          n_chk = 0;
  int          n_fail = 0;
  int          run = 0;
  int          lat = 0;
  bit          rnd_en = 1'b0;
  logic [18:0] q0[$];
  logic [18:0] q1[$];
  logic [15:0] ea, eb;

  always #5 clk = ~clk;

  fifo36_to_fifo19 #(.LE(0)) u_be (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .f36_datain(din), .f36_src_rdy_i(src), .f36_dst_rdy_o(dst0),
    .f19_dataout(d0), .f19_src_rdy_o(s19_0), .f19_dst_rdy_i(dst19),
    .pkt_count(pc0), .framing_err(fe0), .debug(dbg0));

  fifo36_to_fifo19 #(.LE(1)) u_le (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .f36_datain(din), .f36_src_rdy_i(src), .f36_dst_rdy_o(dst1),
    .f19_dataout(d1), .f19_src_rdy_o(s19_1), .f19_dst_rdy_i(dst19),
    .pkt_count(pc1), .framing_err(fe1), .debug(dbg1));

  always @(negedge clk) begin
    if (reset_n && !clear) begin
      if (s19_0 && dst19) q0.push_back(d0);
      if (s19_1 && dst19) q1.push_back(d1);
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1 dst19 = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic sof,
                      input logic eof, input logic [1:0] occ);
    bit acc;
    int k;
    acc = 1'b0;
    k = 0;
    din = {occ, eof, sof, d};
    src = 1'b1;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = dst0;
      @(posedge clk);
      #1;
      k++;
    end
    src = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while ((q0.size() < n || q1.size() < n) && k < 500) begin
      step(1);
      k++;
    end
    step(3);
    chk("qsize_be", q0.size(), n);
    chk("qsize_le", q1.size(), n);
  endtask

  initial begin
    step(3);
    chk("rst_dst_rdy", 32'(dst0), 0);
    chk("rst_src_rdy", 32'(s19_0), 0);
    chk("rst_pkt_count", 32'(pc0), 0);
    chk("rst_framing", 32'(fe0), 0);
    chk("rst_debug", dbg0, 0);
    reset_n = 1'b1;
    step(1);
    chk("idle_dst_rdy", 32'(dst0), 1);

    // full single-word packet, both endiannesses
    send(32'hAABBCCDD, 1'b1, 1'b1, 2'd0);
    lat = 0;
    while (!s19_0 && lat < 5) begin
      step(1);
      lat++;
    end
    chk("first_latency_ok", 32'(lat <= 2), 1);
    wait_q(2);
    chk("w4_be_0", 32'(q0[0]), 32'h1AABB);
    chk("w4_be_1", 32'(q0[1]), 32'h2CCDD);
    chk("w4_le_0", 32'(q1[0]), 32'h1CCDD);
    chk("w4_le_1", 32'(q1[1]), 32'h2AABB);
    chk("w4_pkt_count", 32'(pc0), 1);
    chk("w4_pkt_count_le", 32'(pc1), 1);

    q0.delete(); q1.delete();
    send(32'h11223344, 1'b1, 1'b1, 2'd2);
    wait_q(1);
    chk("occ2_be", 32'(q0[0]), 32'h31122);
    chk("occ2_le", 32'(q1[0]), 32'h33344);
    chk("occ2_pkt_count", 32'(pc0), 2);

    q0.delete(); q1.delete();
    send(32'h11223344, 1'b1, 1'b1, 2'd1);
    wait_q(1);
    chk("occ1_be", 32'(q0[0]), 32'h71122);
    chk("occ1_pkt_count", 32'(pc0), 3);

    q0.delete(); q1.delete();
    send(32'h11223344, 1'b1, 1'b1, 2'd3);
    wait_q(2);
    chk("occ3_be_0", 32'(q0[0]), 32'h11122);
    chk("occ3_be_1", 32'(q0[1]), 32'h63344);
    chk("occ3_pkt_count", 32'(pc0), 4);
    chk("occ_framing", 32'(fe0), 0);

    // 100-word packet at full rate
    q0.delete(); q1.delete();
    run = 0;
    fork
      begin
        for (int i = 0; i < 100; i++)
          send({8'hA0, i[7:0], 8'hB0, i[7:0]}, i == 0, i == 99, 2'd0);
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!s19_0 && k < 100) begin
          @(negedge clk);
          k++;
        end
        while (s19_0 && run < 300) begin
          run++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_contiguous", run, 200);
    wait_q(200);
    for (int j = 0; j < 100; j++) begin
      ea = {8'hA0, j[7:0]};
      eb = {8'hB0, j[7:0]};
      chk("b2b_be_hi", 32'(q0[2*j]), {13'b0, 2'b00, 1'(j == 0), ea});
      chk("b2b_be_lo", 32'(q0[2*j+1]), {13'b0, 1'b0, 1'(j == 99), 1'b0, eb});
      chk("b2b_le_hi", 32'(q1[2*j]), {13'b0, 2'b00, 1'(j == 0), eb});
    end
    chk("b2b_pkt_count", 32'(pc0), 5);
    chk("b2b_framing", 32'(fe0), 0);

    // random output backpressure
    q0.delete(); q1.delete();
    rnd_en = 1'b1;
    for (int i = 0; i < 20; i++)
      send({8'hC0, i[7:0], 8'hD0, i[7:0]}, i == 0, i == 19, 2'd0);
    wait_q(40);
    rnd_en = 1'b0;
    step(2);
    dst19 = 1'b1;
    for (int j = 0; j < 20; j++) begin
      ea = {8'hC0, j[7:0]};
      eb = {8'hD0, j[7:0]};
      chk("rnd_be_hi", 32'(q0[2*j][15:0]), 32'(ea));
      chk("rnd_be_lo", 32'(q0[2*j+1][15:0]), 32'(eb));
    end
    chk("rnd_pkt_count", 32'(pc0), 6);

    // word offered together with clear is dropped
    q0.delete(); q1.delete();
    din = {2'd0, 1'b1, 1'b1, 32'hDEADBEEF};
    src = 1'b1;
    clear = 1'b1;
    step(1);
    src = 1'b0;
    clear = 1'b0;
    step(5);
    chk("clr_discard_q", q0.size(), 0);
    chk("clr_discard_state", dbg0, 0);
    chk("clr_keeps_count", 32'(pc0), 6);

    // framing error after reset, then clear
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    q0.delete(); q1.delete();
    send(32'h55667788, 1'b0, 1'b1, 2'd0);
    wait_q(2);
    chk("nosof_framing", 32'(fe0), 1);
    chk("nosof_be_0", 32'(q0[0]), 32'h05566);
    chk("nosof_be_1", 32'(q0[1]), 32'h27788);
    chk("nosof_le_0", 32'(q1[0]), 32'h07788);
    chk("nosof_pkt_count", 32'(pc0), 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk("clr_framing", 32'(fe0), 0);
    chk("clr_pkt_count", 32'(pc0), 1);

    q0.delete(); q1.delete();
    send(32'h01020304, 1'b1, 1'b0, 2'd0);
    chk("inpkt_no_err", 32'(fe0), 0);
    send(32'h05060708, 1'b1, 1'b1, 2'd0);
    wait_q(4);
    chk("dup_sof_framing", 32'(fe0), 1);
    chk("dup_sof_pkt_count", 32'(pc0), 2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // reset while presenting the second half
    q0.delete(); q1.delete();
    send(32'h99887766, 1'b1, 1'b0, 2'd0);
    step(1);
    chk("half1_state", 32'(dbg0[1:0]), 2);
    reset_n = 1'b0;
    step(1);
    chk("mid_rst_src_rdy", 32'(s19_0), 0);
    chk("mid_rst_pkt_count", 32'(pc0), 0);
    chk("mid_rst_dst_rdy", 32'(dst0), 0);
    reset_n = 1'b1;
    step(1);
    q0.delete(); q1.delete();
    send(32'hAABBCCDD, 1'b1, 1'b1, 2'd0);
    wait_q(2);
    chk("post_rst_be_0", 32'(q0[0]), 32'h1AABB);
    chk("post_rst_be_1", 32'(q0[1]), 32'h2CCDD);
    chk("post_rst_pkt_count", 32'(pc0), 1);
    chk("post_rst_framing", 32'(fe0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
